// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC sample averager: FSM states, readout selects
// and the default code width.
package tdc_pkg;

   localparam int CODE_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [1:0] SEL_MEAN   = 2'd0;
   localparam logic [1:0] SEL_MIN    = 2'd1;
   localparam logic [1:0] SEL_MAX    = 2'd2;
   localparam logic [1:0] SEL_STATUS = 2'd3;

endpackage

// File: rtl/tdc_minmax.sv
// Running minimum/maximum tracker over a window of TDC codes.
// min_next/max_next include the sample presented this cycle.
module tdc_minmax
   import tdc_pkg::*;
#(
   parameter int CODE_W = CODE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              sample_valid,
   input  logic [CODE_W-1:0] sample,
   output logic [CODE_W-1:0] run_min,
   output logic [CODE_W-1:0] run_max,
   output logic [CODE_W-1:0] min_next,
   output logic [CODE_W-1:0] max_next
);

   // Fold the current sample into the running extremes.
   always_comb begin
      min_next = run_min;
      max_next = run_max;
      if (sample_valid && (sample < run_min)) begin
         min_next = sample;
      end else begin
         min_next = run_min;
      end
      if (sample_valid && (sample > run_max)) begin
         max_next = sample;
      end else begin
         max_next = run_max;
      end
   end

   // Running extremes; a clear restarts from the empty-window values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_min <= {CODE_W{1'b1}};
         run_max <= {CODE_W{1'b0}};
      end else if (clear) begin
         run_min <= {CODE_W{1'b1}};
         run_max <= {CODE_W{1'b0}};
      end else begin
         run_min <= min_next;
         run_max <= max_next;
      end
   end

endmodule

// File: rtl/tdc_sample_averager.sv
// Collects 2^LOG2_N qualified TDC codes per window and publishes mean/min/max
// plus a status byte through an 8-bit readout mux.
module tdc_sample_averager
   import tdc_pkg::*;
#(
   parameter int CODE_W = CODE_W_DEF,
   parameter int LOG2_N = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              continuous,
   input  logic [CODE_W-1:0] code_in,
   input  logic              code_valid,
   input  logic [1:0]        rd_sel,
   output logic [7:0]        data_out,
   output logic              busy,
   output logic              done
);

   localparam int ACC_W = CODE_W + LOG2_N;
   localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
   localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1'b1);

   state_e              state_r, state_next_s;
   logic [ACC_W-1:0]    acc_r, acc_sum_s;
   logic [LOG2_N-1:0]   cnt_r;
   logic [CODE_W-1:0]   mean_r, min_r, max_r;
   logic [CODE_W-1:0]   run_min_s, run_max_s, min_next_s, max_next_s;
   logic [3:0]          win_cnt_r;
   logic                busy_r, done_r;
   logic                clear_s, sample_en_s, latch_s;

   assign acc_sum_s = acc_r + ACC_W'(code_in);

   tdc_minmax #(.CODE_W(CODE_W)) u_minmax (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear_s),
      .sample_valid (sample_en_s),
      .sample       (code_in),
      .run_min      (run_min_s),
      .run_max      (run_max_s),
      .min_next     (min_next_s),
      .max_next     (max_next_s)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state and datapath controls; start always beats a completing sample.
   always_comb begin
      state_next_s = state_r;
      clear_s      = 1'b0;
      sample_en_s  = 1'b0;
      latch_s      = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               state_next_s = ACCUM;
               clear_s      = 1'b1;
            end else begin
               state_next_s = state_r;
            end
         end
         ACCUM: begin
            if (start) begin
               clear_s = 1'b1;
            end else if (code_valid) begin
               sample_en_s = 1'b1;
               if (cnt_r == CNT_LAST) begin
                  latch_s = 1'b1;
                  if (continuous) begin
                     clear_s = 1'b1;
                  end else begin
                     state_next_s = DONE;
                  end
               end else begin
                  latch_s = 1'b0;
               end
            end else begin
               sample_en_s = 1'b0;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Accumulator, sample counter, result registers and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r     <= {ACC_W{1'b0}};
         cnt_r     <= {LOG2_N{1'b0}};
         mean_r    <= {CODE_W{1'b0}};
         min_r     <= {CODE_W{1'b0}};
         max_r     <= {CODE_W{1'b0}};
         win_cnt_r <= 4'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         if (clear_s) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {LOG2_N{1'b0}};
         end else if (sample_en_s) begin
            acc_r <= acc_sum_s;
            cnt_r <= cnt_r + CNT_ONE;
         end
         if (latch_s) begin
            mean_r    <= acc_sum_s[ACC_W-1:LOG2_N];
            min_r     <= min_next_s;
            max_r     <= max_next_s;
            win_cnt_r <= win_cnt_r + 4'd1;
         end
         busy_r <= (state_next_s == ACCUM);
         // Level while parked in DONE, single pulse on a continuous completion.
         done_r <= latch_s | (state_next_s == DONE);
      end
   end

   assign busy = busy_r;
   assign done = done_r;

   // Readout mux over the result registers.
   always_comb begin
      data_out = 8'd0;
      case (rd_sel)
         SEL_MEAN:   data_out = 8'(mean_r);
         SEL_MIN:    data_out = 8'(min_r);
         SEL_MAX:    data_out = 8'(max_r);
         SEL_STATUS: data_out = {busy_r, done_r, continuous, 1'b0, win_cnt_r};
         default:    data_out = 8'd0;
      endcase
   end

endmodule
